data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Backing-memory responder on the memory side of the data cache's refill/write-through port.
- Serves one outstanding request at a time with a fixed, parameterised access latency:
  - word reads for cache line fills;
  - byte, half-word and word writes for write-through stores.
- Sits between the data cache and the byte-addressed data RAM. Its response handshake stalls the cache until the access completes.

Parameters:
- ADDR_WIDTH, 32, request address width (byte address).
- DATA_WIDTH, 32, data word width. Fixed at 32; other values are unsupported.
- MEM_ADDR_WIDTH, 17, log2 of RAM size in bytes. Upper address bits are ignored, so accesses wrap.
- LATENCY, 4, cycles from request acceptance to response valid. Must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write (store), 0 = read (refill).
- req_addr_mode  in  3  `DATA_ADDR_MODE_*` encoding from def.sv.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half-word in [15:0]).
- resp_valid  out  1  response available.
- resp_ready  in  1  cache consumes the response.
- resp_rdata  out  DATA_WIDTH  aligned word read. Zero for write responses.
- resp_we  out  1  echoes req_we of the request being answered.

Behaviour:
- Reset: async assert of rst_n forces
  - state = IDLE, req_ready=0 while rst_n low, resp_valid=0, resp_rdata=0, resp_we=0, counter=0.
  - RAM contents are not cleared.
  - After deassertion, req_ready=1 from the first rising edge.
- Reset mid-operation: the in-flight request is dropped silently. A write already committed at acceptance stays committed.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready (acceptance edge T):
    - latch req_we and aligned address;
    - perform write / capture read data;
    - load counter = LATENCY-1;
    - go to WAIT, or straight to RESP if LATENCY==1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: resp_valid=1, and resp_rdata/resp_we are held stable until resp_valid&&resp_ready. Then go to IDLE.
- Latency: resp_valid rises exactly LATENCY cycles after the acceptance edge (visible in cycle T+LATENCY).
- Throughput: no bypass. After the response handshake, req_ready returns the following cycle. Minimum spacing between acceptances is LATENCY+1 cycles.
- Alignment: word index = req_addr[MEM_ADDR_WIDTH-1:2].
  - Reads always return the full aligned word, little-endian (byte 0 in [7:0]), regardless of mode.
- Writes by mode:
  - B/BU: byte lane addr[1:0] receives wdata[7:0].
  - H/HU: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0]; addr[0] is ignored.
  - W and any other encoding: all four lanes receive wdata; addr[1:0] is ignored.
- Ordering: a write commits at its acceptance edge, and a read samples the RAM at its acceptance edge. A read issued after a write therefore always observes it.
- A read-modify of the same word by consecutive byte writes accumulates correctly.
- req_valid while not ready: ignored. The cache must hold the request stable until accepted.
- Address wrap: addresses differing only above MEM_ADDR_WIDTH alias to the same location.

Decomposition:
- Shared package / def.sv holds:
  - the `DATA_ADDR_MODE_*` constants (existing);
  - a new mem_req_t packed struct {we, addr_mode, addr, wdata};
  - the responder state enum {IDLE, WAIT, RESP}.
- One natural sub-module: data_mem_ram, a byte-lane-enabled synchronous word RAM (4 write enables, one read port) instantiated by the responder.

Test Plan:
1. Reset, then W-mode write of 0xDEADBEEF to 0x100, then read of 0x100, with resp_ready=1:
   - each response arrives exactly 4 cycles after acceptance;
   - read resp_rdata=0xDEADBEEF, resp_we=0.
2. Word 0x104 pre-written with 0x00000000, then B-mode writes of 0x11 to 0x104, 0x22 to 0x105, 0x33 to 0x106, 0x44 to 0x107:
   - a read of 0x104 returns 0x44332211.
3. Word 0x108 = 0xFFFFFFFF, then H-mode write of 0x1234ABCD to 0x10B:
   - read of 0x108 returns 0xABCDFFFF.
4. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises:
   - resp_valid and resp_rdata stay stable;
   - req_ready stays 0;
   - on the resp_ready=1 edge, resp_valid drops and req_ready=1 the next cycle.
5. Write 0xCAFEF00D to 0x0000_0200, then read 0x0002_0200 with MEM_ADDR_WIDTH=17:
   - returns 0xCAFEF00D (address wrap).
6. Assert rst_n=0 two cycles after accepting a read:
   - resp_valid=0 immediately (asynchronously) and stays 0;
   - after release, req_ready=1;
   - an earlier committed write is still readable.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared definitions for the data-memory responder.
//                - DATA_ADDR_MODE_* access-size encodings (load/store funct3
//                  style, as used by the data cache).
//                - mem_req_t request bundle.
//                - Responder FSM state encoding.
//                - Helpers that turn a mode/offset into byte-lane enables and
//                  lane-replicated write data.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
    localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
    localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
    localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
    localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

    localparam int MEM_REQ_ADDR_W = 32;
    localparam int MEM_REQ_DATA_W = 32;

    typedef struct packed {
        logic                      we;
        logic [2:0]                addr_mode;
        logic [MEM_REQ_ADDR_W-1:0] addr;
        logic [MEM_REQ_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rsp_state_e;

    // Byte lanes touched by a store. Half-words ignore addr[0]; word and any
    // unknown encoding write the whole word.
    function automatic logic [3:0] mode_byte_en(input logic [2:0] mode,
                                                input logic [1:0] off);
        logic [3:0] be;
        case (mode)
            DATA_ADDR_MODE_B,
            DATA_ADDR_MODE_BU: be = 4'b0001 << off;
            DATA_ADDR_MODE_H,
            DATA_ADDR_MODE_HU: be = off[1] ? 4'b1100 : 4'b0011;
            default:           be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicate it so every candidate lane
    // already carries the right byte and the enables alone pick the target.
    function automatic logic [31:0] mode_lane_data(input logic [2:0]  mode,
                                                   input logic [31:0] wdata);
        logic [31:0] d;
        case (mode)
            DATA_ADDR_MODE_B,
            DATA_ADDR_MODE_BU: d = {4{wdata[7:0]}};
            DATA_ADDR_MODE_H,
            DATA_ADDR_MODE_HU: d = {2{wdata[15:0]}};
            default:           d = wdata;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ram
//  Description : Byte-lane-enabled synchronous word RAM, one shared port.
//                Each lane is its own 8-bit array so per-lane writes never
//                share a storage variable. Reads are registered and the read
//                register only reloads on a read, so rdata holds between reads.
//  Ports       : clk    - clock
//                en     - access strobe (one access per asserted cycle)
//                we     - 1 = write, 0 = read
//                be     - byte-lane write enables (lane 0 = bits [7:0])
//                addr   - word address
//                wdata  - lane-aligned write data
//                rdata  - registered read data (little-endian word)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ram #(
    parameter int WORD_AW = 15
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [3:0]         be,
    input  logic [WORD_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam int DEPTH = 1 << WORD_AW;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Contents are intentionally never reset.
        always_ff @(posedge clk) begin
            if (en && we && be[l]) begin
                mem[addr] <= wdata[8*l +: 8];
            end
            if (en && !we) begin
                rd_q <= mem[addr];
            end
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Backing-memory responder on the data cache refill /
//                write-through port. One request in flight, fixed LATENCY
//                cycles from acceptance to response, response held until the
//                cache takes it.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                req_valid/ready  - request handshake
//                req_we           - 1 = store, 0 = refill read
//                req_addr_mode    - DATA_ADDR_MODE_* access size
//                req_addr         - byte address (wraps above MEM_ADDR_WIDTH)
//                req_wdata        - right-aligned store data
//                resp_valid/ready - response handshake
//                resp_rdata       - aligned word (zero for writes)
//                resp_we          - echo of the answered request's req_we
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_addr_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_we
);

    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int               WORD_AW  = MEM_ADDR_WIDTH - 2;

    mem_req_t    w_req;
    logic        w_accept;
    logic [31:0] w_ram_rdata;
    logic        w_unused_addr_hi;

    rsp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             we_q,    we_d;
    logic             ready_q, ready_d;

    assign w_req.we        = req_we;
    assign w_req.addr_mode = req_addr_mode;
    assign w_req.addr      = MEM_REQ_ADDR_W'(req_addr);
    assign w_req.wdata     = MEM_REQ_DATA_W'(req_wdata);

    // Bits above the RAM size are deliberately ignored so accesses alias.
    assign w_unused_addr_hi = ^w_req.addr[MEM_REQ_ADDR_W-1:MEM_ADDR_WIDTH];

    assign w_accept = req_valid && ready_q;

    // The RAM does all the work at the acceptance edge: a store commits and a
    // read captures its word into the RAM's read register, which then holds
    // until the next read. No address needs to be kept past that edge.
    data_mem_ram #(
        .WORD_AW (WORD_AW)
    ) u_ram (
        .clk   (clk),
        .en    (w_accept),
        .we    (w_req.we),
        .be    (mode_byte_en(w_req.addr_mode, w_req.addr[1:0])),
        .addr  (w_req.addr[MEM_ADDR_WIDTH-1:2]),
        .wdata (mode_lane_data(w_req.addr_mode, w_req.wdata)),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        case (state_q)
            RSP_IDLE: begin
                if (w_accept) begin
                    we_d    = w_req.we;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RSP_RESP : RSP_WAIT;
                end
            end
            RSP_WAIT: begin
                // Leave when the counter reaches zero, so the acceptance edge
                // plus LATENCY-1 waiting edges gives LATENCY in total.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RSP_RESP;
                end
            end
            RSP_RESP: begin
                if (resp_ready) begin
                    state_d = RSP_IDLE;
                end
            end
            default: state_d = RSP_IDLE;
        endcase
        // Registered so ready stays low through reset and only rises on the
        // first edge after release.
        ready_d = (state_d == RSP_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = (state_q == RSP_RESP);
    assign resp_we    = resp_valid && we_q;
    assign resp_rdata = (resp_valid && !we_q) ? DATA_WIDTH'(w_ram_rdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder with a byte-array
//                reference memory and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int LAT   = 4;
    localparam int MEMB  = 1 << 17;

    localparam logic [2:0] M_B  = 3'b000;
    localparam logic [2:0] M_H  = 3'b001;
    localparam logic [2:0] M_W  = 3'b010;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_we;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [MEMB];

    data_mem_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_ADDR_WIDTH (17),
        .LATENCY        (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr_mode (req_addr_mode),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_we       (resp_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void mdl_write(input logic [2:0] mode, input logic [31:0] addr,
                                      input logic [31:0] wd);
        int unsigned a;
        a = int'(addr[16:0]);
        if (mode == 3'b000 || mode == 3'b100) begin
            mdl[a] = wd[7:0];
        end else if (mode == 3'b001 || mode == 3'b101) begin
            a = a & ~32'd1;
            mdl[a]     = wd[7:0];
            mdl[a + 1] = wd[15:8];
        end else begin
            a = a & ~32'd3;
            for (int i = 0; i < 4; i++) mdl[a + i] = wd[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        int unsigned a;
        a = int'(addr[16:0]) & ~32'd3;
        return {mdl[a + 3], mdl[a + 2], mdl[a + 1], mdl[a]};
    endfunction

    // Called at a falling edge; returns at a falling edge after the handshake.
    task automatic txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wd, input int bp, output logic [31:0] rd);
        int n;
        logic [31:0] exp;
        rd = '0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid     = 1'b1;
        req_we        = we;
        req_addr_mode = mode;
        req_addr      = addr;
        req_wdata     = wd;
        resp_ready    = 1'b0;
        if (we) begin
            mdl_write(mode, addr, wd);
            exp = '0;
        end else begin
            exp = mdl_read(addr);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        check("resp_we", 32'(resp_we), 32'(we));
        check(we ? "wr_rdata" : "rd_rdata", resp_rdata, exp);
        rd = resp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, exp);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic [31:0] a;
        logic        we;
        logic [2:0]  mode;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr_mode = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_we", 32'(resp_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Word write then read back
        txn(1'b1, M_W, 32'h100, 32'hDEADBEEF, 0, rd);
        txn(1'b0, M_W, 32'h100, 32'h0, 0, rd);
        check("t1_word", rd, 32'hDEADBEEF);

        // Byte writes accumulate in one word
        txn(1'b1, M_W, 32'h104, 32'h0, 0, rd);
        txn(1'b1, M_B, 32'h104, 32'h11, 0, rd);
        txn(1'b1, M_B, 32'h105, 32'h22, 0, rd);
        txn(1'b1, M_B, 32'h106, 32'h33, 0, rd);
        txn(1'b1, M_B, 32'h107, 32'h44, 0, rd);
        txn(1'b0, M_B, 32'h104, 32'h0, 0, rd);
        check("t2_bytes", rd, 32'h44332211);

        // Half-word write to the upper half, addr[0] ignored
        txn(1'b1, M_W, 32'h108, 32'hFFFFFFFF, 0, rd);
        txn(1'b1, M_H, 32'h10B, 32'h1234ABCD, 0, rd);
        txn(1'b0, M_W, 32'h108, 32'h0, 0, rd);
        check("t3_half", rd, 32'hABCDFFFF);

        // Response backpressure
        txn(1'b0, M_W, 32'h100, 32'h0, 5, rd);
        check("t4_bp_word", rd, 32'hDEADBEEF);

        // Address wrap above MEM_ADDR_WIDTH
        txn(1'b1, M_W, 32'h0000_0200, 32'hCAFEF00D, 0, rd);
        txn(1'b0, M_W, 32'h0002_0200, 32'h0, 0, rd);
        check("t5_wrap", rd, 32'hCAFEF00D);

        // Randomized traffic over a small region with aliased upper bits
        for (int i = 0; i < 16; i++) begin
            r = $urandom();
            txn(1'b1, M_W, 32'h300 + 32'(4 * i), r, 0, rd);
        end
        for (int i = 0; i < 60; i++) begin
            r    = $urandom();
            a    = {r[31:17], 17'h00300 + 17'($urandom_range(0, 63))};
            we   = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            txn(we, mode, a, $urandom(), $urandom_range(0, 2), rd);
        end

        // Reset two cycles after accepting a read
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr_mode = M_W; req_addr = 32'h108;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(resp_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("t6_hold_valid", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_rel", 32'(req_ready), 32'd1);
        repeat (LAT + 2) begin
            @(negedge clk);
            check("t6_no_stale", 32'(resp_valid), 32'd0);
        end

        // Reset while a response is being held must drop it without an edge
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr_mode = M_W; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (LAT) @(negedge clk);
        check("t6b_valid_pre", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_async_drop", 32'(resp_valid), 32'd0);
        check("t6b_async_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, M_W, 32'h100, 32'h0, 0, rd);
        check("t6_mem_kept", rd, 32'hDEADBEEF);
        txn(1'b0, M_W, 32'h200, 32'h0, 1, rd);
        check("t6_mem_kept2", rd, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
